// File: rtl/led_scan_ctrl.sv
// HUB75-style LED panel scan controller.
// Walks each PWM step through SHIFT (two cycles per column), a one-cycle
// LATCH and HOLD cycles of DISPLAY. It drives the framebuffer read address,
// the shared PWM compare value and the panel control pins.
// Every output is a flop, so the panel pins carry no combinational glitches.
module led_scan_ctrl #(
  parameter int PWM_WIDTH = 12,
  parameter int COLS      = 32,
  parameter int COL_BITS  = 5,
  parameter int ROW_BITS  = 4,
  parameter int HOLD      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [PWM_WIDTH-1:0] pwm,
  output logic                 fb_rd,
  output logic [ROW_BITS-1:0]  fb_row,
  output logic [COL_BITS-1:0]  fb_col,
  output logic                 panel_sclk,
  output logic                 panel_latch,
  output logic                 panel_oe_n,
  output logic [ROW_BITS-1:0]  panel_row,
  output logic                 frame_start,
  output logic                 busy
);

  // The hold counter needs at least one bit, even when HOLD is 1.
  localparam int HOLD_BITS = (HOLD > 1) ? $clog2(HOLD) : 1;

  // Catch parameter sets that cannot produce a sensible scan.
  generate
    if (COLS < 2) begin : g_bad_cols
      $error("led_scan_ctrl: COLS must be at least 2");
    end
    if (COLS > (1 << COL_BITS)) begin : g_bad_col_bits
      $error("led_scan_ctrl: COLS does not fit in COL_BITS");
    end
    if (HOLD < 1) begin : g_bad_hold
      $error("led_scan_ctrl: HOLD must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  state_t                state, state_d;
  logic                  phase, phase_d;
  logic [HOLD_BITS-1:0]  hold_cnt, hold_d;
  logic [COL_BITS-1:0]   col_d;
  logic [PWM_WIDTH-1:0]  pwm_d;
  logic [ROW_BITS-1:0]   row_d, prow_d;

  logic last_col;
  logic last_hold;
  logic pwm_max;

  assign last_col  = (fb_col == COL_BITS'(COLS - 1));
  assign last_hold = (hold_cnt == HOLD_BITS'(HOLD - 1));
  assign pwm_max   = (pwm == {PWM_WIDTH{1'b1}});

  // Next-state and next-counter logic for the scan sequence.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    state_d = state;
    phase_d = phase;
    hold_d  = hold_cnt;
    col_d   = fb_col;
    pwm_d   = pwm;
    row_d   = fb_row;
    prow_d  = panel_row;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d = SHIFT;
          phase_d = 1'b0;
          col_d   = '0;
        end
      end

      SHIFT: begin
        if (!phase) begin
          // The read address was presented this cycle. The data is stable
          // next cycle, when the panel clocks it in.
          phase_d = 1'b1;
        end else if (last_col) begin
          state_d = LATCH;
          phase_d = 1'b0;
        end else begin
          col_d   = fb_col + COL_BITS'(1);
          phase_d = 1'b0;
        end
      end

      LATCH: begin
        // The row address follows the data that has just been latched.
        prow_d  = fb_row;
        hold_d  = '0;
        state_d = DISPLAY;
      end

      DISPLAY: begin
        if (last_hold) begin
          hold_d = '0;
          pwm_d  = pwm + PWM_WIDTH'(1);
          if (pwm_max) begin
            row_d = fb_row + ROW_BITS'(1);
          end
          // enable is only honoured at step boundaries, so a step is never
          // cut short.
          if (enable) begin
            state_d = SHIFT;
            phase_d = 1'b0;
            col_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_cnt + HOLD_BITS'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers. Reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= 1'b0;
      hold_cnt  <= '0;
      fb_col    <= '0;
      pwm       <= '0;
      fb_row    <= '0;
      panel_row <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge value of every other register.
      state     <= state_d;
      phase     <= phase_d;
      hold_cnt  <= hold_d;
      fb_col    <= col_d;
      pwm       <= pwm_d;
      fb_row    <= row_d;
      panel_row <= prow_d;
    end
  end

  // Decoded control outputs are registered from the next state, so they line
  // up with the state and counter registers above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_rd       <= 1'b0;
      panel_sclk  <= 1'b0;
      panel_latch <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fb_rd       <= (state_d == SHIFT) && !phase_d;
      panel_sclk  <= (state_d == SHIFT) && phase_d;
      panel_latch <= (state_d == LATCH);
      // LEDs are lit only in DISPLAY. This keeps them dark during shifting
      // and latching.
      panel_oe_n  <= (state_d != DISPLAY);
      busy        <= (state_d != IDLE);
      // A frame starts on the first SHIFT cycle of a step whose counters are
      // both zero. This covers a restart from IDLE as well.
      frame_start <= (state_d == SHIFT) && (state != SHIFT) &&
                     (pwm_d == '0) && (row_d == '0);
    end
  end

endmodule
